// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display refresh path: frame geometry, the refresh
// sequencer state encoding and the widths of its internal counters.
// -----------------------------------------------------------------------------
package display_pkg;

    // Frame geometry: six seven-segment digits, shifted out as one frame.
    localparam int DISPLAY_DIGITS = 6;
    localparam int SEG_PER_DIGIT  = 7;
    localparam int DEFAULT_WIDTH  = DISPLAY_DIGITS * SEG_PER_DIGIT;

    // Internal counter widths of the refresh sequencer.
    localparam int SETTLE_CNT_W  = 4;
    localparam int TIMEOUT_CNT_W = 16;

    // Refresh sequencer states. Encodings are fixed so status/debug taps
    // elsewhere in the system can decode them.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_START     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// Loadable down-counter with a zero flag. Counting stops at zero (no wrap), so
// the zero flag stays asserted until the next load.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset (count -> 0)
//   load_i      load load_val_i this cycle (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one if not already zero
//   zero_o      count is currently zero
// -----------------------------------------------------------------------------
module cycle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/display_update_sequencer.sv
// -----------------------------------------------------------------------------
// display_update_sequencer
// Schedules refreshes of the serial seven-segment shift register. A refresh
// request (a seconds tick or an MSF time load) waits SETTLE_CYCLES for the
// digit counters to settle, snapshots the live segment frame into a holding
// register and pulses the shift register start. Requests arriving during a
// refresh are coalesced into a single follow-up refresh.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset (shared with shift_reg)
//   second_inc_i   one-cycle pulse: seconds digit advanced
//   time_load_i    one-cycle pulse: decoded MSF time loaded
//   seg_i          live seven_seg_hms frame
//   shift_latch_i  shift_reg latch_o: transfer complete
//   shift_start_o  one-cycle start pulse to shift_reg
//   shift_data_o   frame snapshot held for the whole transfer
//   locked_o       set by the first time load after reset
//   overrun_o      sticky: request arrived while one was already pending
//   timeout_o      sticky: a transfer never reported completion
// -----------------------------------------------------------------------------
module display_update_sequencer
    import display_pkg::*;
#(
    parameter int               WIDTH          = DEFAULT_WIDTH,
    parameter int               SETTLE_CYCLES  = 2,
    parameter int               TIMEOUT_CYCLES = 255,
    parameter logic [WIDTH-1:0] BLANK_PATTERN  = {WIDTH{1'b0}}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             second_inc_i,
    input  logic             time_load_i,
    input  logic [WIDTH-1:0] seg_i,
    input  logic             shift_latch_i,
    output logic             shift_start_o,
    output logic [WIDTH-1:0] shift_data_o,
    output logic             locked_o,
    output logic             overrun_o,
    output logic             timeout_o
);

    localparam logic [SETTLE_CNT_W-1:0]  SETTLE_LOAD  = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LOAD = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             locked_q, locked_d;
    logic             blink_q, blink_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             req;
    logic             settle_load, settle_dec, settle_zero;
    logic             to_load, to_dec, to_zero;
    logic             xfer_done;

    // A tick and a time load in the same cycle are a single request.
    assign req = second_inc_i | time_load_i;

    cycle_timer #(
        .CNT_W (SETTLE_CNT_W)
    ) u_settle_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (settle_load),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (settle_dec),
        .zero_o     (settle_zero)
    );

    cycle_timer #(
        .CNT_W (TIMEOUT_CNT_W)
    ) u_timeout_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (to_load),
        .load_val_i (TIMEOUT_LOAD),
        .dec_i      (to_dec),
        .zero_o     (to_zero)
    );

    // Lock and blink status. Unlocked, the display blinks at half the seconds
    // rate; once locked it is always shown.
    always_comb begin
        locked_d = locked_q | time_load_i;
        blink_d  = blink_q;
        if (locked_q) begin
            blink_d = 1'b1;
        end else if (second_inc_i) begin
            blink_d = ~blink_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        data_d      = data_q;
        settle_load = 1'b0;
        settle_dec  = 1'b0;
        to_load     = 1'b0;
        to_dec      = 1'b0;
        xfer_done   = 1'b0;

        // Any request while a refresh is in progress is remembered once;
        // further requests on top of that are only flagged.
        if ((state_q != ST_IDLE) && req) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d     = ST_SETTLE;
                    settle_load = 1'b1;
                end
            end

            ST_SETTLE: begin
                settle_dec = 1'b1;
                if (settle_zero) begin
                    state_d = ST_START;
                    // The snapshot is taken only here, so the frame cannot
                    // change underneath an active transfer.
                    data_d  = (locked_q || blink_q) ? seg_i : BLANK_PATTERN;
                end
            end

            ST_START: begin
                to_load = 1'b1;
                state_d = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                to_dec = 1'b1;
                if (shift_latch_i) begin
                    xfer_done = 1'b1;
                end else if (to_zero) begin
                    xfer_done = 1'b1;
                    timeout_d = 1'b1;
                end
                if (xfer_done) begin
                    // A request in the completion cycle itself also counts
                    // as pending; if one was already pending it stays queued.
                    if (pending_q || req) begin
                        state_d     = ST_SETTLE;
                        settle_load = 1'b1;
                        pending_d   = pending_q & req;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            locked_q  <= 1'b0;
            blink_q   <= 1'b1;
            data_q    <= BLANK_PATTERN;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            locked_q  <= locked_d;
            blink_q   <= blink_d;
            data_q    <= data_d;
        end
    end

    // START lasts exactly one cycle, so the start pulse is one cycle wide and
    // can never repeat back to back.
    assign shift_start_o = (state_q == ST_START);
    assign shift_data_o  = data_q;
    assign locked_o      = locked_q;
    assign overrun_o     = overrun_q;
    assign timeout_o     = timeout_q;

endmodule
